// File: rtl/lcd_menu_writer_if.sv
// Avalon-MM bus between the menu writer (master) and the LCD_Controller (slave).
interface lcd_menu_writer_if;
  logic       address;
  logic       chipselect;
  logic       byteenable;
  logic       read;
  logic       write;
  logic [7:0] writedata;
  logic       waitrequest;
  logic [7:0] readdata;
  logic [1:0] response;

  modport master (
    output address, chipselect, byteenable, read, write, writedata,
    input  waitrequest, readdata, response
  );

  modport slave (
    input  address, chipselect, byteenable, read, write, writedata,
    output waitrequest, readdata, response
  );
endinterface

// File: rtl/lcd_menu_writer.sv
// Menu writer: renders a scrollable N_OPTIONS menu on the LCD controller over
// Avalon-MM, redraws whenever the highlighted option changes, and latches the
// option confirmed by a select pulse.
module lcd_menu_writer #(
  parameter int N_OPTIONS = 4,
  parameter int N_CHARS   = 16,
  parameter int TWO_LINE  = 1,
  parameter int WRAP      = 1,
  localparam int OPT_W    = (N_OPTIONS > 2) ? $clog2(N_OPTIONS) : 1,
  localparam int COL_W    = (N_CHARS > 2) ? $clog2(N_CHARS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 nav_left,
  input  logic                 nav_right,
  input  logic                 select,
  lcd_menu_writer_if.master    bus,
  output logic [OPT_W-1:0]     text_option,
  output logic                 text_line,
  output logic [COL_W-1:0]     text_col,
  input  logic [7:0]           text_char,
  output logic [OPT_W-1:0]     option,
  output logic [OPT_W-1:0]     menu_choice,
  output logic                 choice_valid,
  output logic                 busy
);

  localparam int N_STEPS = 1 + N_CHARS + TWO_LINE * (1 + N_CHARS);
  localparam int STEP_W  = $clog2(N_STEPS + 1);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(N_STEPS - 1);
  localparam logic [OPT_W-1:0]  LAST_OPT  = OPT_W'(N_OPTIONS - 1);

  typedef enum logic [1:0] {IDLE, WRITE_OP, GAP} state_t;

  state_t              state, state_next;
  logic [STEP_W-1:0]   step, step_next;
  logic [OPT_W-1:0]    draw_opt, draw_opt_next;
  logic                load_draw;
  logic                pending;
  logic [OPT_W-1:0]    option_next;
  logic                option_changes;

  logic                is_cmd;
  logic [7:0]          cmd_data;
  logic                line_sel;
  logic [COL_W-1:0]    col_sel;

  logic                write_c;
  logic                address_c;
  logic [7:0]          writedata_c;

  logic                unused_bus;

  assign unused_bus = ^{bus.readdata, bus.response};

  // Decode the current step into a command byte or a (line, column) text fetch
  always_comb begin
    is_cmd   = 1'b1;
    cmd_data = 8'h01;
    line_sel = 1'b0;
    col_sel  = '0;
    if (step == '0) begin
      cmd_data = 8'h01;
    end else if (step <= STEP_W'(N_CHARS)) begin
      is_cmd  = 1'b0;
      col_sel = COL_W'(step - STEP_W'(1));
    end else if (step == STEP_W'(N_CHARS + 1)) begin
      cmd_data = 8'hC0;
    end else begin
      is_cmd   = 1'b0;
      line_sel = 1'b1;
      col_sel  = COL_W'(step - STEP_W'(N_CHARS + 2));
    end
  end

  assign text_option = draw_opt;
  assign text_line   = line_sel;
  assign text_col    = col_sel;

  // Draw sequencer: next state, step/option bookkeeping and bus drive
  always_comb begin
    state_next    = state;
    step_next     = step;
    draw_opt_next = draw_opt;
    load_draw     = 1'b0;
    write_c       = 1'b0;
    address_c     = 1'b0;
    writedata_c   = 8'h00;
    case (state)
      IDLE: begin
        if (pending) begin
          load_draw     = 1'b1;
          draw_opt_next = option;
          step_next     = '0;
          state_next    = WRITE_OP;
        end
      end
      WRITE_OP: begin
        write_c     = 1'b1;
        address_c   = ~is_cmd;
        writedata_c = is_cmd ? cmd_data : text_char;
        if (!bus.waitrequest) begin
          if (step == LAST_STEP && !pending) state_next = IDLE;
          else                               state_next = GAP;
        end
      end
      GAP: begin
        if (pending) begin
          load_draw     = 1'b1;
          draw_opt_next = option;
          step_next     = '0;
        end else begin
          step_next = step + STEP_W'(1);
        end
        state_next = WRITE_OP;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.write      = write_c;
  assign bus.chipselect = write_c;
  assign bus.address    = address_c;
  assign bus.writedata  = writedata_c;
  assign bus.byteenable = 1'b1;
  assign bus.read       = 1'b0;

  // Sequencer state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      step     <= '0;
      draw_opt <= '0;
    end else begin
      state    <= state_next;
      step     <= step_next;
      draw_opt <= draw_opt_next;
    end
  end

  // Navigation: move the highlight, wrapping or saturating; both pulses cancel
  always_comb begin
    option_next = option;
    if (nav_right && !nav_left) begin
      if (option == LAST_OPT) option_next = (WRAP != 0) ? '0 : option;
      else                    option_next = option + OPT_W'(1);
    end else if (nav_left && !nav_right) begin
      if (option == '0) option_next = (WRAP != 0) ? LAST_OPT : option;
      else              option_next = option - OPT_W'(1);
    end
  end

  assign option_changes = (option_next != option);

  // Option, redraw request and confirmed-choice registers; a new change wins
  // over the sequencer consuming the previous request
  always_ff @(posedge clk) begin
    if (reset) begin
      option       <= '0;
      pending      <= 1'b1;
      menu_choice  <= '0;
      choice_valid <= 1'b0;
    end else begin
      option <= option_next;
      if (option_changes) pending <= 1'b1;
      else if (load_draw) pending <= 1'b0;
      if (select) menu_choice <= option;
      choice_valid <= select;
    end
  end

  assign busy = (state != IDLE) || pending;

endmodule

// File: tb/tb_lcd_menu_writer.sv
// Self-checking bench: three menu writers (default, saturating, 5-option
// single-line) with a scoreboard of expected Avalon writes.
module tb_lcd_menu_writer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  logic [2:0] nav_l, nav_r, sel, wreq;

  lcd_menu_writer_if bus_a ();
  lcd_menu_writer_if bus_b ();
  lcd_menu_writer_if bus_c ();

  assign bus_a.waitrequest = wreq[0];
  assign bus_b.waitrequest = wreq[1];
  assign bus_c.waitrequest = wreq[2];
  assign bus_a.readdata = 8'h00;
  assign bus_b.readdata = 8'h00;
  assign bus_c.readdata = 8'h00;
  assign bus_a.response = 2'b00;
  assign bus_b.response = 2'b00;
  assign bus_c.response = 2'b00;

  logic [1:0] to_a, opt_a, mc_a, to_b, opt_b, mc_b;
  logic [2:0] to_c, opt_c, mc_c;
  logic       tl_a, tl_b, tl_c, cv_a, cv_b, cv_c, busy_a, busy_b, busy_c;
  logic [3:0] col_a, col_b, col_c;
  logic [7:0] ch_a, ch_b, ch_c;

  // Text lookup: distinct text per option, line and column
  function automatic logic [7:0] charOf(input int opt, input int line, input int col);
    return 8'(8'h41 + col + line * 16 + opt * 32);
  endfunction

  assign ch_a = charOf(int'(to_a), int'(tl_a), int'(col_a));
  assign ch_b = charOf(int'(to_b), int'(tl_b), int'(col_b));
  assign ch_c = charOf(int'(to_c), int'(tl_c), int'(col_c));

  lcd_menu_writer #(.N_OPTIONS(4), .N_CHARS(16), .TWO_LINE(1), .WRAP(1)) dut_a (
    .clk(clk), .reset(reset), .nav_left(nav_l[0]), .nav_right(nav_r[0]), .select(sel[0]),
    .bus(bus_a), .text_option(to_a), .text_line(tl_a), .text_col(col_a), .text_char(ch_a),
    .option(opt_a), .menu_choice(mc_a), .choice_valid(cv_a), .busy(busy_a));

  lcd_menu_writer #(.N_OPTIONS(4), .N_CHARS(16), .TWO_LINE(1), .WRAP(0)) dut_b (
    .clk(clk), .reset(reset), .nav_left(nav_l[1]), .nav_right(nav_r[1]), .select(sel[1]),
    .bus(bus_b), .text_option(to_b), .text_line(tl_b), .text_col(col_b), .text_char(ch_b),
    .option(opt_b), .menu_choice(mc_b), .choice_valid(cv_b), .busy(busy_b));

  lcd_menu_writer #(.N_OPTIONS(5), .N_CHARS(16), .TWO_LINE(0), .WRAP(1)) dut_c (
    .clk(clk), .reset(reset), .nav_left(nav_l[2]), .nav_right(nav_r[2]), .select(sel[2]),
    .bus(bus_c), .text_option(to_c), .text_line(tl_c), .text_col(col_c), .text_char(ch_c),
    .option(opt_c), .menu_choice(mc_c), .choice_valid(cv_c), .busy(busy_c));

  // Reference model state
  logic [8:0] q_a[$], q_b[$], q_c[$];
  int n_opt[3]  = '{4, 4, 5};
  int wrap_m[3] = '{1, 0, 1};
  int two_m[3]  = '{1, 1, 0};
  int mdl_opt[3];
  int mdl_choice[3];
  int acc[3];
  logic [2:0] gapchk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected {address, data} for one step of a 16-column draw
  function automatic logic [8:0] stepWord(input int opt, input int s);
    if (s == 0)  return 9'h001;
    if (s <= 16) return {1'b1, charOf(opt, 0, s - 1)};
    if (s == 17) return 9'h0C0;
    return {1'b1, charOf(opt, 1, s - 18)};
  endfunction

  function automatic int qSize(input int idx);
    case (idx)
      0: return q_a.size();
      1: return q_b.size();
      default: return q_c.size();
    endcase
  endfunction

  function automatic int optOf(input int idx);
    case (idx)
      0: return int'(opt_a);
      1: return int'(opt_b);
      default: return int'(opt_c);
    endcase
  endfunction

  function automatic logic busyOf(input int idx);
    case (idx)
      0: return busy_a;
      1: return busy_b;
      default: return busy_c;
    endcase
  endfunction

  function automatic logic cvOf(input int idx);
    case (idx)
      0: return cv_a;
      1: return cv_b;
      default: return cv_c;
    endcase
  endfunction

  function automatic int mcOf(input int idx);
    case (idx)
      0: return int'(mc_a);
      1: return int'(mc_b);
      default: return int'(mc_c);
    endcase
  endfunction

  task automatic pushDraw(input int idx, input int opt);
    int n;
    n = (two_m[idx] != 0) ? 34 : 17;
    for (int s = 0; s < n; s++) begin
      case (idx)
        0: q_a.push_back(stepWord(opt, s));
        1: q_b.push_back(stepWord(opt, s));
        default: q_c.push_back(stepWord(opt, s));
      endcase
    end
  endtask

  task automatic sbPop(input int idx, input logic [8:0] got);
    logic [8:0] w;
    if (qSize(idx) == 0) begin
      checkOutput($sformatf("sb%0d_unexpected_write", idx), qSize(idx), 1);
    end else begin
      case (idx)
        0: w = q_a.pop_front();
        1: w = q_b.pop_front();
        default: w = q_c.pop_front();
      endcase
      checkOutput($sformatf("sb%0d_write", idx), got, w);
    end
  endtask

  task automatic monitorStep(input int idx, input logic w, input logic wt, input logic cs,
                             input logic a, input logic [7:0] d);
    if (gapchk[idx]) begin
      checkOutput($sformatf("gap%0d_write", idx), w, 0);
      checkOutput($sformatf("gap%0d_data", idx), d, 0);
    end
    gapchk[idx] = 1'b0;
    if (w && !wt) begin
      checkOutput($sformatf("cs%0d", idx), cs, 1);
      sbPop(idx, {a, d});
      acc[idx]++;
      gapchk[idx] = 1'b1;
    end
  endtask

  // Scoreboard monitor, sampling away from the active edge
  always @(negedge clk) begin
    if (reset) begin
      gapchk = 3'b000;
    end else begin
      monitorStep(0, bus_a.write, bus_a.waitrequest, bus_a.chipselect, bus_a.address, bus_a.writedata);
      monitorStep(1, bus_b.write, bus_b.waitrequest, bus_b.chipselect, bus_b.address, bus_b.writedata);
      monitorStep(2, bus_c.write, bus_c.waitrequest, bus_c.chipselect, bus_c.address, bus_c.writedata);
    end
  end

  // Drive one navigation/select pulse, update the model and check the response
  task automatic applyStimulus(input int idx, input logic l, input logic r, input logic s);
    int prev, nxt;
    prev = mdl_opt[idx];
    nxt  = prev;
    if (r && !l)      nxt = (prev == n_opt[idx] - 1) ? ((wrap_m[idx] != 0) ? 0 : prev) : prev + 1;
    else if (l && !r) nxt = (prev == 0) ? ((wrap_m[idx] != 0) ? n_opt[idx] - 1 : prev) : prev - 1;
    if (nxt != prev) pushDraw(idx, nxt);
    if (s) mdl_choice[idx] = prev;
    mdl_opt[idx] = nxt;
    @(posedge clk); #1;
    nav_l[idx] = l; nav_r[idx] = r; sel[idx] = s;
    @(posedge clk); #1;
    nav_l[idx] = 1'b0; nav_r[idx] = 1'b0; sel[idx] = 1'b0;
    @(negedge clk);
    checkOutput($sformatf("option%0d", idx), optOf(idx), nxt);
    if (s) begin
      checkOutput($sformatf("choice_valid%0d_hi", idx), cvOf(idx), 1);
      checkOutput($sformatf("menu_choice%0d", idx), mcOf(idx), mdl_choice[idx]);
    end
    @(negedge clk);
    if (s) checkOutput($sformatf("choice_valid%0d_lo", idx), cvOf(idx), 0);
    checkOutput($sformatf("busy%0d_after_nav", idx), busyOf(idx), (nxt != prev) ? 1 : 0);
  endtask

  task automatic waitIdle(input int idx, input string tag);
    int cyc;
    cyc = 0;
    while ((qSize(idx) != 0 || busyOf(idx)) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput({tag, "_busy"}, busyOf(idx), 0);
    checkOutput({tag, "_queue_left"}, qSize(idx), 0);
  endtask

  task automatic waitAcc(input int idx, input int target);
    int cyc;
    cyc = 0;
    while (acc[idx] < target && cyc < 500) begin
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput($sformatf("reach_write_%0d", target), acc[idx], target);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    reset = 1'b1;
    nav_l = '0; nav_r = '0; sel = '0; wreq = '0;
    gapchk = '0;
    for (int i = 0; i < 3; i++) begin
      mdl_opt[i] = 0; mdl_choice[i] = 0; acc[i] = 0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_option", opt_a, 0);
    checkOutput("rst_menu_choice", mc_a, 0);
    checkOutput("rst_choice_valid", cv_a, 0);
    checkOutput("rst_write", bus_a.write, 0);
    checkOutput("rst_writedata", bus_a.writedata, 0);
    checkOutput("rst_address", bus_a.address, 0);
    checkOutput("rst_read", bus_a.read, 0);
    checkOutput("rst_byteenable", bus_a.byteenable, 1);
    checkOutput("rst_busy_pending", busy_a, 1);
    checkOutput("rst_option_c", opt_c, 0);

    pushDraw(0, 0); pushDraw(1, 0); pushDraw(2, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Stall step 3 of the first draw for five cycles
    waitAcc(0, 3);
    wreq[0] = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput("stall_write", bus_a.write, 1);
      checkOutput("stall_word", {bus_a.address, bus_a.writedata}, stepWord(0, 3));
    end
    @(posedge clk); #1;
    wreq[0] = 1'b0;
    waitIdle(0, "first_draw_a");
    checkOutput("first_draw_a_count", acc[0], 34);
    waitIdle(1, "first_draw_b");
    waitIdle(2, "first_draw_c");
    checkOutput("first_draw_c_count", acc[2], 17);

    // Wrap at both ends
    applyStimulus(0, 1'b1, 1'b0, 1'b0);
    waitIdle(0, "wrap_left_a");
    applyStimulus(0, 1'b0, 1'b1, 1'b0);
    waitIdle(0, "wrap_right_a");

    // Saturation: presses at the ends do nothing
    applyStimulus(1, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 1'b0, 1'b1, 1'b0);
      waitIdle(1, "sat_step_b");
    end
    base = acc[1];
    applyStimulus(1, 1'b0, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    checkOutput("sat_no_write_b", acc[1] - base, 0);
    checkOutput("sat_busy_b", busy_b, 0);

    // Mid-draw navigation restarts the draw after the in-flight write
    applyStimulus(0, 1'b1, 1'b0, 1'b0);
    waitIdle(0, "pre_restart_a");
    base = acc[0];
    applyStimulus(0, 1'b0, 1'b1, 1'b0);
    waitAcc(0, base + 10);
    wreq[0] = 1'b1;
    while (q_a.size() > 1) void'(q_a.pop_back());
    applyStimulus(0, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    wreq[0] = 1'b0;
    waitIdle(0, "restart_a");
    checkOutput("restart_count_a", acc[0] - base, 11 + 34);

    // Simultaneous left/right cancels
    base = acc[0];
    applyStimulus(0, 1'b1, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("both_no_write_a", acc[0] - base, 0);

    // Select, alone and together with navigation
    applyStimulus(0, 1'b0, 1'b1, 1'b0);
    waitIdle(0, "to_two_a");
    applyStimulus(0, 1'b0, 1'b0, 1'b1);
    applyStimulus(0, 1'b0, 1'b1, 1'b1);
    waitIdle(0, "select_nav_a");

    // Five options, single line: wrap left and right
    base = acc[2];
    applyStimulus(2, 1'b1, 1'b0, 1'b0);
    waitIdle(2, "wrap_left_c");
    checkOutput("wrap_left_c_count", acc[2] - base, 17);
    applyStimulus(2, 1'b0, 1'b1, 1'b0);
    waitIdle(2, "wrap_right_c");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/lcd_menu_writer.md
Name: lcd_menu_writer

Overview:
Parametrised Avalon-MM master that drives the LCD_Controller slave to render a scrollable menu of N_OPTIONS entries. Text comes from an external combinational lookup. Left/right navigation pulses move the highlighted option, with wrap or saturate behaviour, and trigger a redraw. A select pulse latches the confirmed choice for downstream logic. It sits between the button_edge detectors and the LCD controller, and is the generalised successor of the fixed four-option, single-line menu writer.

Parameters:
N_OPTIONS, 4, number of menu entries (>=2)
N_CHARS, 16, characters written per display line (1..40)
TWO_LINE, 1, 1 = also write line 2 after DDRAM-address command 0xC0; 0 = line 1 only
WRAP, 1, 1 = navigation wraps at the ends; 0 = navigation saturates at the ends
Derived: OPT_W = max(1, clog2(N_OPTIONS)); COL_W = max(1, clog2(N_CHARS)); N_STEPS = 1 + N_CHARS + TWO_LINE*(1 + N_CHARS)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
nav_left  in  1  single-cycle pulse: previous option
nav_right  in  1  single-cycle pulse: next option
select  in  1  single-cycle pulse: confirm current option
address  out  1  Avalon address; 0 = command, 1 = data
chipselect  out  1  equals write
byteenable  out  1  constant 1
read  out  1  constant 0
write  out  1  Avalon write request
writedata  out  8  Avalon write data; 0 when write=0
waitrequest  in  1  slave stall
readdata  in  8  unused
response  in  2  unused
text_option  out  OPT_W  option whose text is being fetched
text_line  out  1  line being fetched (0/1)
text_col  out  COL_W  column being fetched
text_char  in  8  ASCII for (text_option, text_line, text_col), combinational, same cycle
option  out  OPT_W  current highlighted option
menu_choice  out  OPT_W  last confirmed option
choice_valid  out  1  one-cycle pulse when menu_choice updates
busy  out  1  high while a draw sequence is in progress or pending

Behaviour:
- Reset values: option=0, menu_choice=0, choice_valid=0, write=0, writedata=0, address=0, state=IDLE, step=0, pending=1, so option 0 is drawn automatically after reset.
- Step map per draw:
  - step 0: address 0, data 0x01 (clear display).
  - steps 1..N_CHARS: address 1, data text_char with line 0, col = step-1.
  - If TWO_LINE: step N_CHARS+1 is address 0, data 0xC0. Steps N_CHARS+2..N_STEPS-1 are address 1, line 1, col = step-N_CHARS-2.
  - text_line and text_col outputs are 0 on command steps.
- FSM states: IDLE, WRITE_OP, GAP.
  - IDLE: if pending, clear pending, latch draw_opt <= option, step <= 0, go to WRITE_OP.
  - WRITE_OP: write=1. address and writedata stay stable until waitrequest is sampled low. On ~waitrequest: if step == N_STEPS-1 and !pending, go to IDLE; otherwise go to GAP.
  - GAP: write=0 for exactly one cycle. If pending: clear pending, latch draw_opt <= option, step <= 0. Otherwise step <= step+1. Go to WRITE_OP.
- text_option = draw_opt, latched at step 0, so a mid-draw navigation never mixes text from two options.
- Mid-draw navigation: the in-flight write is never aborted. The sequence restarts from step 0 at the next GAP.
- Navigation, registered with effect on the next cycle:
  - nav_right: option+1. At N_OPTIONS-1 it goes to 0 (WRAP=1) or holds (WRAP=0).
  - nav_left: option-1. At 0 it goes to N_OPTIONS-1 (WRAP=1) or holds (WRAP=0).
  - Modulo N_OPTIONS, which need not be a power of 2.
  - nav_left and nav_right in the same cycle: no change, no redraw.
  - pending is set only when option actually changes; a saturated press does nothing.
- select: menu_choice <= option (the pre-navigation value if nav arrives in the same cycle). choice_valid is high for exactly the following cycle. Allowed during busy.
- busy = (state != IDLE) | pending.
- Reset asserted mid-transaction forces write low at the next edge. The interconnect shares the same reset.

Test Plan:
- Reset, waitrequest=0, lookup returns 0x41+col: exactly 34 writes, in order 0x01/a0, 16x 0x41..0x50/a1, 0xC0/a0, 16 data writes. write low for 1 cycle between writes. busy falls after the last write.
- waitrequest held high 5 cycles on step 3: write, address and writedata stay stable for all 6 cycles; the next write carries step 4 data.
- WRAP=1, option=3, nav_right: option=0 and a redraw with text_option=0. WRAP=0, option=3, nav_right: option stays 3, no write, busy stays 0.
- nav_right during step 10 of an option-0 draw: step 10 completes, the next write is 0x01, text_option=1 thereafter, and there are 34 writes after the restart.
- nav_left and nav_right in the same cycle: option unchanged, no redraw. select with option=2: menu_choice=2, choice_valid high for 1 cycle.
- N_OPTIONS=5, TWO_LINE=0, option=0, nav_left: option=4, and the redraw is 17 writes with no 0xC0.
